// File: rtl/reservation_station_pkg.sv
// Shared definitions for the reservation station and its neighbours.
// Holds the tag/data widths, the "no tag" encoding, the ROB entry state
// encoding shared with reorder_buffer, the station entry record and the
// CDB operand-capture helper used by every entry.
package reservation_station_pkg;

    localparam int TAG_WIDTH  = 8;
    localparam int DATA_WIDTH = 32;
    localparam int OP_WIDTH   = 6;

    localparam logic [TAG_WIDTH-1:0] RSTAG_NULL = 8'hFF;

    typedef enum logic [1:0] {
        ROBE_EMPTY     = 2'd0,
        ROBE_ISSUED    = 2'd1,
        ROBE_EXECUTED  = 2'd2,
        ROBE_COMMITTED = 2'd3
    } robe_state_t;

    typedef struct packed {
        logic [TAG_WIDTH-1:0]  tag;
        logic [DATA_WIDTH-1:0] value;
    } rs_src_t;

    typedef struct packed {
        logic                  valid;
        logic [OP_WIDTH-1:0]   op;
        logic [TAG_WIDTH-1:0]  tag;
        logic [TAG_WIDTH-1:0]  rs1_tag;
        logic [DATA_WIDTH-1:0] rs1_value;
        logic [TAG_WIDTH-1:0]  rs2_tag;
        logic [DATA_WIDTH-1:0] rs2_value;
    } rs_entry_t;

    localparam rs_entry_t RS_ENTRY_RESET = '{
        valid:     1'b0,
        op:        '0,
        tag:       RSTAG_NULL,
        rs1_tag:   RSTAG_NULL,
        rs1_value: '0,
        rs2_tag:   RSTAG_NULL,
        rs2_value: '0
    };

    // Capture a pending operand from the CDBs. A source that is already
    // ready never matches, so an idle CDB (RSTAG_NULL) is harmless.
    // cdb1 is checked first so it wins when both buses carry the same tag.
    function automatic rs_src_t resolve_src(
        input rs_src_t               src,
        input logic [TAG_WIDTH-1:0]  cdb1_tag,
        input logic [DATA_WIDTH-1:0] cdb1_value,
        input logic [TAG_WIDTH-1:0]  cdb2_tag,
        input logic [DATA_WIDTH-1:0] cdb2_value
    );
        rs_src_t res;
        res = src;
        if (src.tag != RSTAG_NULL) begin
            if (src.tag == cdb1_tag) begin
                res.tag   = RSTAG_NULL;
                res.value = cdb1_value;
            end else if (src.tag == cdb2_tag) begin
                res.tag   = RSTAG_NULL;
                res.value = cdb2_value;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/reservation_station_entry.sv
// One reservation station slot.
// Holds op, destination tag and two source operands. On a write the
// incoming operands pass through the same CDB capture as wakeup, which
// gives dispatch/CDB bypass for free.
// Ports:
//   clock, reset          clock, async active-low reset
//   flush_i               invalidate this slot at the edge
//   write_en_i, write_*   dispatch into this slot (slot is free)
//   clear_i               slot is issuing this cycle; free it
//   cdb*_tag_i/value_i    CDB broadcasts
//   valid_o, ready_o      slot occupied / both sources ready
//   op_o, tag_o, rs*_value_o  slot contents for issue
module reservation_station_entry
    import reservation_station_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush_i,
    input  logic                  write_en_i,
    input  logic [OP_WIDTH-1:0]   write_op_i,
    input  logic [TAG_WIDTH-1:0]  write_tag_i,
    input  rs_src_t               write_rs1_i,
    input  rs_src_t               write_rs2_i,
    input  logic                  clear_i,
    input  logic [TAG_WIDTH-1:0]  cdb1_tag_i,
    input  logic [DATA_WIDTH-1:0] cdb1_value_i,
    input  logic [TAG_WIDTH-1:0]  cdb2_tag_i,
    input  logic [DATA_WIDTH-1:0] cdb2_value_i,
    output logic                  valid_o,
    output logic                  ready_o,
    output logic [OP_WIDTH-1:0]   op_o,
    output logic [TAG_WIDTH-1:0]  tag_o,
    output logic [DATA_WIDTH-1:0] rs1_value_o,
    output logic [DATA_WIDTH-1:0] rs2_value_o
);

    rs_entry_t entry_q, entry_d;
    rs_src_t   rs1_src, rs2_src, rs1_res, rs2_res;

    always_comb begin
        // Either the dispatched operand or the held one goes through capture.
        rs1_src = write_en_i ? write_rs1_i
                             : '{tag: entry_q.rs1_tag, value: entry_q.rs1_value};
        rs2_src = write_en_i ? write_rs2_i
                             : '{tag: entry_q.rs2_tag, value: entry_q.rs2_value};
        rs1_res = resolve_src(rs1_src, cdb1_tag_i, cdb1_value_i, cdb2_tag_i, cdb2_value_i);
        rs2_res = resolve_src(rs2_src, cdb1_tag_i, cdb1_value_i, cdb2_tag_i, cdb2_value_i);

        entry_d = entry_q;
        if (flush_i) begin
            entry_d = RS_ENTRY_RESET;
        end else if (write_en_i) begin
            entry_d.valid     = 1'b1;
            entry_d.op        = write_op_i;
            entry_d.tag       = write_tag_i;
            entry_d.rs1_tag   = rs1_res.tag;
            entry_d.rs1_value = rs1_res.value;
            entry_d.rs2_tag   = rs2_res.tag;
            entry_d.rs2_value = rs2_res.value;
        end else if (clear_i) begin
            entry_d.valid = 1'b0;
        end else if (entry_q.valid) begin
            entry_d.rs1_tag   = rs1_res.tag;
            entry_d.rs1_value = rs1_res.value;
            entry_d.rs2_tag   = rs2_res.tag;
            entry_d.rs2_value = rs2_res.value;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            entry_q <= RS_ENTRY_RESET;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign valid_o     = entry_q.valid;
    assign ready_o     = entry_q.valid && (entry_q.rs1_tag == RSTAG_NULL)
                                       && (entry_q.rs2_tag == RSTAG_NULL);
    assign op_o        = entry_q.op;
    assign tag_o       = entry_q.tag;
    assign rs1_value_o = entry_q.rs1_value;
    assign rs2_value_o = entry_q.rs2_value;

endmodule

// File: rtl/reservation_station.sv
// Dual-dispatch reservation station.
// Accepts up to two instructions per cycle into free slots, snoops two CDBs
// for missing operands and issues the lowest-index fully ready slot over a
// valid/ready handshake. A flush empties every slot.
// Ports:
//   clock, reset                    clock, async active-low reset
//   inst1_*_in, inst2_*_in          dispatch slots (valid, op, tag, sources)
//   cdb1_*_in, cdb2_*_in            CDB broadcasts (RSTAG_NULL = idle)
//   flush_in                        mispredict flush
//   issue_ready_in                  functional unit accepts
//   stall_out                       fewer than two free slots
//   issue_valid_out, issue_*_out    selected slot for issue
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int RS_ENTRIES = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  inst1_valid_in,
    input  logic [OP_WIDTH-1:0]   inst1_op_in,
    input  logic [TAG_WIDTH-1:0]  inst1_tag_in,
    input  logic [TAG_WIDTH-1:0]  inst1_rs1_tag_in,
    input  logic [TAG_WIDTH-1:0]  inst1_rs2_tag_in,
    input  logic [DATA_WIDTH-1:0] inst1_rs1_value_in,
    input  logic [DATA_WIDTH-1:0] inst1_rs2_value_in,
    input  logic                  inst2_valid_in,
    input  logic [OP_WIDTH-1:0]   inst2_op_in,
    input  logic [TAG_WIDTH-1:0]  inst2_tag_in,
    input  logic [TAG_WIDTH-1:0]  inst2_rs1_tag_in,
    input  logic [TAG_WIDTH-1:0]  inst2_rs2_tag_in,
    input  logic [DATA_WIDTH-1:0] inst2_rs1_value_in,
    input  logic [DATA_WIDTH-1:0] inst2_rs2_value_in,
    input  logic [TAG_WIDTH-1:0]  cdb1_tag_in,
    input  logic [DATA_WIDTH-1:0] cdb1_value_in,
    input  logic [TAG_WIDTH-1:0]  cdb2_tag_in,
    input  logic [DATA_WIDTH-1:0] cdb2_value_in,
    input  logic                  flush_in,
    input  logic                  issue_ready_in,
    output logic                  stall_out,
    output logic                  issue_valid_out,
    output logic [OP_WIDTH-1:0]   issue_op_out,
    output logic [TAG_WIDTH-1:0]  issue_tag_out,
    output logic [DATA_WIDTH-1:0] issue_rs1_value_out,
    output logic [DATA_WIDTH-1:0] issue_rs2_value_out
);

    localparam int IDX_W = (RS_ENTRIES > 1) ? $clog2(RS_ENTRIES) : 1;
    localparam int CNT_W = $clog2(RS_ENTRIES + 1);

    logic [RS_ENTRIES-1:0] valid_vec, ready_vec, we1, we2, clear_en;
    logic [OP_WIDTH-1:0]   op_arr   [RS_ENTRIES];
    logic [TAG_WIDTH-1:0]  tag_arr  [RS_ENTRIES];
    logic [DATA_WIDTH-1:0] rs1_arr  [RS_ENTRIES];
    logic [DATA_WIDTH-1:0] rs2_arr  [RS_ENTRIES];

    logic [CNT_W-1:0] free_cnt;
    logic [IDX_W-1:0] free_idx1, free_idx2, sel_idx;
    logic             free_found1, free_found2, sel_found;
    logic             accept;
    rs_src_t          in1_rs1, in1_rs2, in2_rs1, in2_rs2;

    assign in1_rs1 = '{tag: inst1_rs1_tag_in, value: inst1_rs1_value_in};
    assign in1_rs2 = '{tag: inst1_rs2_tag_in, value: inst1_rs2_value_in};
    assign in2_rs1 = '{tag: inst2_rs1_tag_in, value: inst2_rs1_value_in};
    assign in2_rs2 = '{tag: inst2_rs2_tag_in, value: inst2_rs2_value_in};

    // Free count and the two lowest free slots, from registered state only;
    // a slot issuing this cycle is still counted as occupied.
    always_comb begin
        free_cnt    = '0;
        free_found1 = 1'b0;
        free_found2 = 1'b0;
        free_idx1   = '0;
        free_idx2   = '0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            if (!valid_vec[i]) begin
                free_cnt = free_cnt + CNT_W'(1);
                if (!free_found1) begin
                    free_found1 = 1'b1;
                    free_idx1   = IDX_W'(i);
                end else if (!free_found2) begin
                    free_found2 = 1'b1;
                    free_idx2   = IDX_W'(i);
                end
            end
        end
    end

    assign stall_out = (free_cnt < CNT_W'(2));
    assign accept    = !stall_out && !flush_in;

    // inst2 takes the second free slot only when inst1 is using the first.
    always_comb begin
        we1 = '0;
        we2 = '0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            we1[i] = accept && inst1_valid_in && free_found1 && (free_idx1 == IDX_W'(i));
            if (inst1_valid_in) begin
                we2[i] = accept && inst2_valid_in && free_found2 && (free_idx2 == IDX_W'(i));
            end else begin
                we2[i] = accept && inst2_valid_in && free_found1 && (free_idx1 == IDX_W'(i));
            end
        end
    end

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
            if (ready_vec[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    assign issue_valid_out = sel_found && !flush_in;

    always_comb begin
        issue_op_out        = '0;
        issue_tag_out       = RSTAG_NULL;
        issue_rs1_value_out = '0;
        issue_rs2_value_out = '0;
        if (issue_valid_out) begin
            issue_op_out        = op_arr[sel_idx];
            issue_tag_out       = tag_arr[sel_idx];
            issue_rs1_value_out = rs1_arr[sel_idx];
            issue_rs2_value_out = rs2_arr[sel_idx];
        end
    end

    always_comb begin
        clear_en = '0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            clear_en[i] = issue_valid_out && issue_ready_in && (sel_idx == IDX_W'(i));
        end
    end

    for (genvar g = 0; g < RS_ENTRIES; g++) begin : g_entry
        reservation_station_entry u_entry (
            .clock        (clock),
            .reset        (reset),
            .flush_i      (flush_in),
            .write_en_i   (we1[g] | we2[g]),
            .write_op_i   (we2[g] ? inst2_op_in  : inst1_op_in),
            .write_tag_i  (we2[g] ? inst2_tag_in : inst1_tag_in),
            .write_rs1_i  (we2[g] ? in2_rs1      : in1_rs1),
            .write_rs2_i  (we2[g] ? in2_rs2      : in1_rs2),
            .clear_i      (clear_en[g]),
            .cdb1_tag_i   (cdb1_tag_in),
            .cdb1_value_i (cdb1_value_in),
            .cdb2_tag_i   (cdb2_tag_in),
            .cdb2_value_i (cdb2_value_in),
            .valid_o      (valid_vec[g]),
            .ready_o      (ready_vec[g]),
            .op_o         (op_arr[g]),
            .tag_o        (tag_arr[g]),
            .rs1_value_o  (rs1_arr[g]),
            .rs2_value_o  (rs2_arr[g])
        );
    end

endmodule

// File: tb/tb_reservation_station.sv
module tb_reservation_station;

    logic        clock = 1'b0;
    logic        reset;
    logic        inst1_valid_in, inst2_valid_in;
    logic [5:0]  inst1_op_in, inst2_op_in;
    logic [7:0]  inst1_tag_in, inst1_rs1_tag_in, inst1_rs2_tag_in;
    logic [7:0]  inst2_tag_in, inst2_rs1_tag_in, inst2_rs2_tag_in;
    logic [31:0] inst1_rs1_value_in, inst1_rs2_value_in;
    logic [31:0] inst2_rs1_value_in, inst2_rs2_value_in;
    logic [7:0]  cdb1_tag_in, cdb2_tag_in;
    logic [31:0] cdb1_value_in, cdb2_value_in;
    logic        flush_in, issue_ready_in;
    logic        stall_out, issue_valid_out;
    logic [5:0]  issue_op_out;
    logic [7:0]  issue_tag_out;
    logic [31:0] issue_rs1_value_out, issue_rs2_value_out;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [5:0]  op;
        logic [7:0]  tag;
        logic [31:0] v1;
        logic [31:0] v2;
    } exp_t;
    exp_t sb[$];

    reservation_station dut (
        .clock               (clock),
        .reset               (reset),
        .inst1_valid_in      (inst1_valid_in),
        .inst1_op_in         (inst1_op_in),
        .inst1_tag_in        (inst1_tag_in),
        .inst1_rs1_tag_in    (inst1_rs1_tag_in),
        .inst1_rs2_tag_in    (inst1_rs2_tag_in),
        .inst1_rs1_value_in  (inst1_rs1_value_in),
        .inst1_rs2_value_in  (inst1_rs2_value_in),
        .inst2_valid_in      (inst2_valid_in),
        .inst2_op_in         (inst2_op_in),
        .inst2_tag_in        (inst2_tag_in),
        .inst2_rs1_tag_in    (inst2_rs1_tag_in),
        .inst2_rs2_tag_in    (inst2_rs2_tag_in),
        .inst2_rs1_value_in  (inst2_rs1_value_in),
        .inst2_rs2_value_in  (inst2_rs2_value_in),
        .cdb1_tag_in         (cdb1_tag_in),
        .cdb1_value_in       (cdb1_value_in),
        .cdb2_tag_in         (cdb2_tag_in),
        .cdb2_value_in       (cdb2_value_in),
        .flush_in            (flush_in),
        .issue_ready_in      (issue_ready_in),
        .stall_out           (stall_out),
        .issue_valid_out     (issue_valid_out),
        .issue_op_out        (issue_op_out),
        .issue_tag_out       (issue_tag_out),
        .issue_rs1_value_out (issue_rs1_value_out),
        .issue_rs2_value_out (issue_rs2_value_out)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, obs, exp, $time);
        end
    endtask

    task automatic idle();
        inst1_valid_in = 1'b0; inst1_op_in = '0; inst1_tag_in = 8'hFF;
        inst1_rs1_tag_in = 8'hFF; inst1_rs2_tag_in = 8'hFF;
        inst1_rs1_value_in = '0; inst1_rs2_value_in = '0;
        inst2_valid_in = 1'b0; inst2_op_in = '0; inst2_tag_in = 8'hFF;
        inst2_rs1_tag_in = 8'hFF; inst2_rs2_tag_in = 8'hFF;
        inst2_rs1_value_in = '0; inst2_rs2_value_in = '0;
        cdb1_tag_in = 8'hFF; cdb1_value_in = '0;
        cdb2_tag_in = 8'hFF; cdb2_value_in = '0;
        flush_in = 1'b0;
    endtask

    task automatic disp1(input logic [5:0] op, input logic [7:0] tag,
                         input logic [7:0] t1, input logic [31:0] v1,
                         input logic [7:0] t2, input logic [31:0] v2);
        inst1_valid_in = 1'b1; inst1_op_in = op; inst1_tag_in = tag;
        inst1_rs1_tag_in = t1; inst1_rs1_value_in = v1;
        inst1_rs2_tag_in = t2; inst1_rs2_value_in = v2;
    endtask

    task automatic disp2(input logic [5:0] op, input logic [7:0] tag,
                         input logic [7:0] t1, input logic [31:0] v1,
                         input logic [7:0] t2, input logic [31:0] v2);
        inst2_valid_in = 1'b1; inst2_op_in = op; inst2_tag_in = tag;
        inst2_rs1_tag_in = t1; inst2_rs1_value_in = v1;
        inst2_rs2_tag_in = t2; inst2_rs2_value_in = v2;
    endtask

    task automatic push(input logic [5:0] op, input logic [7:0] tag,
                        input logic [31:0] v1, input logic [31:0] v2);
        exp_t e;
        e.op = op; e.tag = tag; e.v1 = v1; e.v2 = v2;
        sb.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic mid();
        @(negedge clock);
    endtask

    // Every accepted issue must match a pending expectation by tag.
    always @(negedge clock) begin : monitor
        int hit;
        if (reset && issue_valid_out && issue_ready_in) begin
            hit = -1;
            for (int k = 0; k < sb.size(); k++)
                if (hit < 0 && sb[k].tag == issue_tag_out) hit = k;
            check("sb_hit", 64'(hit >= 0), 64'd1);
            if (hit >= 0) begin
                check("sb_op",  64'(issue_op_out),        64'(sb[hit].op));
                check("sb_rs1", 64'(issue_rs1_value_out), 64'(sb[hit].v1));
                check("sb_rs2", 64'(issue_rs2_value_out), 64'(sb[hit].v2));
                sb.delete(hit);
            end
        end
    end

    initial begin
        reset = 1'b0;
        issue_ready_in = 1'b1;
        idle();
        repeat (3) cyc();
        reset = 1'b1;

        // reset state
        mid();
        check("rst_stall", 64'(stall_out), 64'd0);
        check("rst_valid", 64'(issue_valid_out), 64'd0);
        check("rst_tag",   64'(issue_tag_out), 64'hFF);
        check("rst_op",    64'(issue_op_out), 64'd0);
        check("rst_rs1",   64'(issue_rs1_value_out), 64'd0);
        cyc();

        // ready at dispatch: issues the next cycle, freed the one after
        disp1(6'd1, 8'd3, 8'hFF, 32'd5, 8'hFF, 32'd7);
        push(6'd1, 8'd3, 32'd5, 32'd7);
        mid();
        check("t1_pre_valid", 64'(issue_valid_out), 64'd0);
        cyc(); idle();
        mid();
        check("t1_valid", 64'(issue_valid_out), 64'd1);
        check("t1_tag",   64'(issue_tag_out), 64'd3);
        cyc();
        mid();
        check("t1_freed", 64'(issue_valid_out), 64'd0);
        cyc();

        // CDB wakeup two cycles after dispatch
        disp1(6'd2, 8'd4, 8'd9, 32'd0, 8'hFF, 32'd2);
        push(6'd2, 8'd4, 32'h55, 32'd2);
        cyc(); idle();
        mid();
        check("t2_wait", 64'(issue_valid_out), 64'd0);
        cyc();
        cdb1_tag_in = 8'd9; cdb1_value_in = 32'h55;
        mid();
        check("t2_wake_cycle", 64'(issue_valid_out), 64'd0);
        cyc(); idle();
        mid();
        check("t2_valid", 64'(issue_valid_out), 64'd1);
        check("t2_tag",   64'(issue_tag_out), 64'd4);
        cyc();

        // dispatch/CDB bypass through slot 2 alone
        disp2(6'd3, 8'd5, 8'hFF, 32'h11, 8'h0A, 32'd0);
        cdb2_tag_in = 8'h0A; cdb2_value_in = 32'hAB;
        push(6'd3, 8'd5, 32'h11, 32'hAB);
        mid();
        check("t3_pre_valid", 64'(issue_valid_out), 64'd0);
        cyc(); idle();
        mid();
        check("t3_valid", 64'(issue_valid_out), 64'd1);
        check("t3_rs2",   64'(issue_rs2_value_out), 64'hAB);
        cyc();

        // fill with four unresolved pairs; entry i = tag 0x10+i waiting 0x20+i
        for (int i = 0; i < 4; i++) begin
            disp1(6'd4, 8'(8'h10 + 2*i), 8'(8'h20 + 2*i), 32'd0, 8'hFF, 32'(32'h100 + 2*i));
            disp2(6'd4, 8'(8'h11 + 2*i), 8'(8'h21 + 2*i), 32'd0, 8'hFF, 32'(32'h101 + 2*i));
            mid();
            check("t4_fill_stall", 64'(stall_out), 64'd0);
            cyc();
        end
        idle();
        mid();
        check("t4_full_stall", 64'(stall_out), 64'd1);
        cyc();
        disp1(6'd7, 8'h30, 8'hFF, 32'd1, 8'hFF, 32'd1);
        disp2(6'd7, 8'h31, 8'hFF, 32'd1, 8'hFF, 32'd1);
        cyc(); idle();
        mid();
        check("t4_drop", 64'(issue_valid_out), 64'd0);
        cyc();
        cdb1_tag_in = 8'h20; cdb1_value_in = 32'hE0;
        push(6'd4, 8'h10, 32'hE0, 32'h100);
        cyc(); idle();
        mid();
        check("t4_e0_tag", 64'(issue_tag_out), 64'h10);
        cyc();
        mid();
        check("t4_seven_stall", 64'(stall_out), 64'd1);
        cdb1_tag_in = 8'h21; cdb1_value_in = 32'hE1;
        push(6'd4, 8'h11, 32'hE1, 32'h101);
        cyc(); idle();
        mid();
        check("t4_e1_tag", 64'(issue_tag_out), 64'h11);
        cyc();
        mid();
        check("t4_six_stall", 64'(stall_out), 64'd0);
        cyc();

        // both CDBs carry the same tag: cdb1 wins
        cdb1_tag_in = 8'h22; cdb1_value_in = 32'd1;
        cdb2_tag_in = 8'h22; cdb2_value_in = 32'd2;
        push(6'd4, 8'h12, 32'd1, 32'h102);
        cyc(); idle();
        mid();
        check("t5_tag", 64'(issue_tag_out), 64'h12);
        check("t5_rs1", 64'(issue_rs1_value_out), 64'd1);
        cyc();

        // flush with five valid, one pending issue and a dispatch pair
        issue_ready_in = 1'b0;
        cdb1_tag_in = 8'h23; cdb1_value_in = 32'h33;
        cyc(); idle();
        mid();
        check("t6_pend_tag", 64'(issue_tag_out), 64'h13);
        cyc();
        mid();
        check("t6_hold_tag", 64'(issue_tag_out), 64'h13);
        cyc();
        flush_in = 1'b1;
        issue_ready_in = 1'b1;
        disp1(6'd5, 8'h40, 8'hFF, 32'd1, 8'hFF, 32'd2);
        disp2(6'd5, 8'h41, 8'hFF, 32'd3, 8'hFF, 32'd4);
        mid();
        check("t6_flush_valid", 64'(issue_valid_out), 64'd0);
        cyc(); idle();
        mid();
        check("t6_post_valid", 64'(issue_valid_out), 64'd0);
        check("t6_post_stall", 64'(stall_out), 64'd0);
        cdb1_tag_in = 8'h24; cdb1_value_in = 32'd1;
        cdb2_tag_in = 8'h25; cdb2_value_in = 32'd1;
        cyc(); idle();
        mid();
        check("t6_empty", 64'(issue_valid_out), 64'd0);
        cyc();

        // refill to exactly two free, then one more pair stalls
        for (int i = 0; i < 3; i++) begin
            disp1(6'd6, 8'(8'h50 + 2*i), 8'(8'h60 + 2*i), 32'd0, 8'hFF, 32'd0);
            disp2(6'd6, 8'(8'h51 + 2*i), 8'(8'h61 + 2*i), 32'd0, 8'hFF, 32'd0);
            cyc();
        end
        idle();
        mid();
        check("t7_two_free", 64'(stall_out), 64'd0);
        cyc();
        disp1(6'd6, 8'h56, 8'h66, 32'd0, 8'hFF, 32'd0);
        disp2(6'd6, 8'h57, 8'h67, 32'd0, 8'hFF, 32'd0);
        cyc(); idle();
        mid();
        check("t7_full", 64'(stall_out), 64'd1);
        cyc();

        // async reset mid-cycle with an issue pending
        issue_ready_in = 1'b0;
        cdb1_tag_in = 8'h60; cdb1_value_in = 32'd9;
        cyc(); idle();
        mid();
        check("t8_pend_tag", 64'(issue_tag_out), 64'h50);
        #2;
        reset = 1'b0;
        #1;
        check("t8_rst_valid", 64'(issue_valid_out), 64'd0);
        check("t8_rst_stall", 64'(stall_out), 64'd0);
        check("t8_rst_tag",   64'(issue_tag_out), 64'hFF);
        cyc();
        reset = 1'b1;
        issue_ready_in = 1'b1;
        mid();
        check("t8_after_valid", 64'(issue_valid_out), 64'd0);
        cyc();

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
